pact_lsu_row_fetcher: RTL and testbench

PACT_LSU_ROW_FETCHER -- requirements
Module: pact_lsu_row_fetcher

---
 rtl/pact_lsu_row_fetcher_pkg.sv | 18 +
 rtl/pact_lsu_row_fetcher_assembler.sv | 110 +++++++++++
 rtl/pact_lsu_row_fetcher.sv | 185 ++++++++++++++++++
 tb/tb_pact_lsu_row_fetcher.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pact_lsu_row_fetcher_pkg.sv
// Shared definitions for the LSU row fetcher: FSM states and AXI encodings.
package pact_lsu_row_fetcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // AXI AxSIZE encoding for a transfer of the given number of bytes
  function automatic logic [2:0] axi_size_enc(input int bytes);
    return 3'($clog2(bytes));
  endfunction

endpackage

// File: rtl/pact_lsu_row_fetcher_assembler.sv
// Collects R beats into a row buffer, applies the column mask, emits zero
// padding rows and drives the row-stream handshake.
module pact_lsu_row_assembler
  import pact_lsu_row_fetcher_pkg::*;
#(
  parameter int MATRIX_SIZE = 4,
  parameter int BW_ELEM     = 32,
  parameter int BW_AXI_DATA = 32,
  parameter int BEATS       = 4
) (
  input  logic                             clk,
  input  logic                             rstnn,
  input  logic                             clear,
  input  logic                             active,
  input  logic [$clog2(MATRIX_SIZE)-1:0]   num_row_m1,
  input  logic [$clog2(MATRIX_SIZE)-1:0]   num_col_m1,
  input  logic                             r_valid,
  input  logic [BW_AXI_DATA-1:0]           r_data,
  input  logic                             r_last,
  output logic                             r_ready,
  output logic                             beat_error,
  output logic                             row_valid,
  input  logic                             row_ready,
  output logic [MATRIX_SIZE*BW_ELEM-1:0]   row_data,
  output logic                             row_last
);

  localparam int IW    = $clog2(MATRIX_SIZE);
  localparam int BTW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ROW_W = MATRIX_SIZE * BW_ELEM;

  logic [BTW-1:0]   beat_q, beat_d;
  logic [ROW_W-1:0] buf_q, buf_d;
  logic             full_q, full_d;
  logic [IW-1:0]    out_row_q, out_row_d;

  logic beat_is_last;
  logic padding;
  logic r_hs;
  logic row_hs;

  // Handshake decode: padding rows need no data, real rows wait for the buffer
  always_comb begin
    beat_is_last = (beat_q == BTW'(BEATS - 1));
    padding      = active && (out_row_q > num_row_m1);
    row_valid    = full_q | padding;
    r_ready      = active & ~row_valid;
    r_hs         = r_valid & r_ready;
    beat_error   = r_hs & r_last & ~beat_is_last;
    row_hs       = row_valid & row_ready;
    row_last     = row_valid & (out_row_q == IW'(MATRIX_SIZE - 1));
  end

  // Beat counter, buffer fill and output row index; rlast resyncs the counter
  always_comb begin
    beat_d    = beat_q;
    buf_d     = buf_q;
    full_d    = full_q;
    out_row_d = out_row_q;
    if (clear) begin
      beat_d    = '0;
      full_d    = 1'b0;
      out_row_d = '0;
    end else begin
      if (r_hs) begin
        buf_d[int'(beat_q)*BW_AXI_DATA +: BW_AXI_DATA] = r_data;
        if (beat_is_last) begin
          beat_d = '0;
          full_d = 1'b1;
        end else if (r_last) begin
          beat_d = '0;
        end else begin
          beat_d = beat_q + BTW'(1);
        end
      end
      if (row_hs) begin
        full_d    = 1'b0;
        out_row_d = (out_row_q == IW'(MATRIX_SIZE - 1)) ? '0 : out_row_q + IW'(1);
      end
    end
  end

  // Columns beyond the valid width and whole padding rows read as zero
  always_comb begin
    row_data = '0;
    if (!padding) begin
      for (int c = 0; c < MATRIX_SIZE; c++) begin
        if (c <= int'(num_col_m1)) begin
          row_data[c*BW_ELEM +: BW_ELEM] = buf_q[c*BW_ELEM +: BW_ELEM];
        end
      end
    end
  end

  // Assembler state registers
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      beat_q    <= '0;
      buf_q     <= '0;
      full_q    <= 1'b0;
      out_row_q <= '0;
    end else begin
      beat_q    <= beat_d;
      buf_q     <= buf_d;
      full_q    <= full_d;
      out_row_q <= out_row_d;
    end
  end

endmodule

// File: rtl/pact_lsu_row_fetcher.sv
// Loads a matrix row by row over AXI: one AR burst per valid row, rows
// streamed out in order with column masking and zero padding rows.
module pact_lsu_row_fetcher
  import pact_lsu_row_fetcher_pkg::*;
#(
  parameter int BW_ADDR         = 32,
  parameter int BW_AXI_DATA     = 32,
  parameter int BW_AXI_TID      = 4,
  parameter int MATRIX_SIZE     = 4,
  parameter int BW_ELEM         = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                             clk,
  input  logic                             rstnn,
  input  logic                             start,
  input  logic [BW_ADDR-1:0]               cfg_start_addr,
  input  logic [BW_ADDR-1:0]               cfg_stride,
  input  logic [$clog2(MATRIX_SIZE)-1:0]   cfg_num_row_m1,
  input  logic [$clog2(MATRIX_SIZE)-1:0]   cfg_num_col_m1,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [BW_AXI_TID-1:0]            dma_sxarid,
  output logic [BW_ADDR-1:0]               dma_sxaraddr,
  output logic [7:0]                       dma_sxarlen,
  output logic [2:0]                       dma_sxarsize,
  output logic [1:0]                       dma_sxarburst,
  output logic                             dma_sxarvalid,
  input  logic                             dma_sxarready,
  input  logic [BW_AXI_TID-1:0]            dma_sxrid,
  input  logic [BW_AXI_DATA-1:0]           dma_sxrdata,
  input  logic [1:0]                       dma_sxrresp,
  input  logic                             dma_sxrlast,
  input  logic                             dma_sxrvalid,
  output logic                             dma_sxrready,
  output logic                             row_valid,
  input  logic                             row_ready,
  output logic [MATRIX_SIZE*BW_ELEM-1:0]   row_data,
  output logic                             row_last
);

  localparam int IW    = $clog2(MATRIX_SIZE);
  localparam int BEATS = MATRIX_SIZE * BW_ELEM / BW_AXI_DATA;
  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW    = IW + 1;

  if (BEATS < 1 || BEATS * BW_AXI_DATA != MATRIX_SIZE * BW_ELEM) begin : g_bad_beats
    $error("row width must be a non-zero whole number of AXI beats");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 8) begin : g_bad_outstanding
    $error("MAX_OUTSTANDING must be within 1..8");
  end

  fetch_state_e           state_q, state_d;
  logic [BW_ADDR-1:0]     addr_q, addr_d;
  logic [BW_ADDR-1:0]     stride_q, stride_d;
  logic [IW-1:0]          num_row_m1_q, num_row_m1_d;
  logic [IW-1:0]          num_col_m1_q, num_col_m1_d;
  logic [CW-1:0]          issued_q, issued_d;
  logic [OW-1:0]          outstanding_q, outstanding_d;
  logic                   error_q, error_d;

  logic start_acc;
  logic ar_pending;
  logic ar_hs;
  logic r_hs;
  logic r_last_hs;
  logic row_hs;
  logic beat_error;
  logic unused_rid;

  assign unused_rid = ^dma_sxrid;

  // Handshake decode; a new AR is offered only while rows remain and slots are free
  always_comb begin
    start_acc  = (state_q == ST_IDLE) && start;
    ar_pending = (state_q == ST_RUN) && (issued_q <= {1'b0, num_row_m1_q}) &&
                 (outstanding_q < OW'(MAX_OUTSTANDING));
    ar_hs      = ar_pending & dma_sxarready;
    r_hs       = dma_sxrvalid & dma_sxrready;
    r_last_hs  = r_hs & dma_sxrlast;
    row_hs     = row_valid & row_ready;
  end

  // Load sequencing: the final row handshake ends the run, DONE lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (row_hs && row_last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Config capture, address accumulation, burst bookkeeping and sticky error
  always_comb begin
    addr_d        = addr_q;
    stride_d      = stride_q;
    num_row_m1_d  = num_row_m1_q;
    num_col_m1_d  = num_col_m1_q;
    issued_d      = issued_q;
    outstanding_d = outstanding_q;
    error_d       = error_q;
    if (start_acc) begin
      addr_d        = cfg_start_addr;
      stride_d      = cfg_stride;
      num_row_m1_d  = cfg_num_row_m1;
      num_col_m1_d  = cfg_num_col_m1;
      issued_d      = '0;
      outstanding_d = '0;
      error_d       = 1'b0;
    end else begin
      if (ar_hs) begin
        addr_d   = addr_q + stride_q;
        issued_d = issued_q + CW'(1);
      end
      if (ar_hs && !r_last_hs) begin
        outstanding_d = outstanding_q + OW'(1);
      end else if (!ar_hs && r_last_hs && outstanding_q != '0) begin
        outstanding_d = outstanding_q - OW'(1);
      end
      if ((r_hs && dma_sxrresp != AXI_RESP_OKAY) || beat_error) begin
        error_d = 1'b1;
      end
    end
  end

  // Control registers
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      stride_q      <= '0;
      num_row_m1_q  <= '0;
      num_col_m1_q  <= '0;
      issued_q      <= '0;
      outstanding_q <= '0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      stride_q      <= stride_d;
      num_row_m1_q  <= num_row_m1_d;
      num_col_m1_q  <= num_col_m1_d;
      issued_q      <= issued_d;
      outstanding_q <= outstanding_d;
      error_q       <= error_d;
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign error         = error_q;
  assign dma_sxarid    = '0;
  assign dma_sxaraddr  = addr_q;
  assign dma_sxarlen   = 8'(BEATS - 1);
  assign dma_sxarsize  = axi_size_enc(BW_AXI_DATA / 8);
  assign dma_sxarburst = AXI_BURST_INCR;
  assign dma_sxarvalid = ar_pending;

  pact_lsu_row_assembler #(
    .MATRIX_SIZE (MATRIX_SIZE),
    .BW_ELEM     (BW_ELEM),
    .BW_AXI_DATA (BW_AXI_DATA),
    .BEATS       (BEATS)
  ) u_assembler (
    .clk        (clk),
    .rstnn      (rstnn),
    .clear      (start_acc),
    .active     (state_q == ST_RUN),
    .num_row_m1 (num_row_m1_q),
    .num_col_m1 (num_col_m1_q),
    .r_valid    (dma_sxrvalid),
    .r_data     (dma_sxrdata),
    .r_last     (dma_sxrlast),
    .r_ready    (dma_sxrready),
    .beat_error (beat_error),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .row_data   (row_data),
    .row_last   (row_last)
  );

endmodule

// File: tb/tb_pact_lsu_row_fetcher.sv
// Self-checking bench: AXI slave model, row sink and a matrix reference model.
module tb_pact_lsu_row_fetcher;

  localparam int MS    = 4;
  localparam int MO    = 2;
  localparam int BEATS = 4;

  logic         clk = 1'b0;
  logic         rstnn, start;
  logic [31:0]  cfg_start_addr, cfg_stride;
  logic [1:0]   cfg_num_row_m1, cfg_num_col_m1;
  logic         busy, done, error;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid, arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast, rvalid, rready;
  logic         row_valid, row_ready, row_last;
  logic [127:0] row_data;

  always #5 clk = ~clk;

  pact_lsu_row_fetcher dut (
    .clk(clk), .rstnn(rstnn), .start(start),
    .cfg_start_addr(cfg_start_addr), .cfg_stride(cfg_stride),
    .cfg_num_row_m1(cfg_num_row_m1), .cfg_num_col_m1(cfg_num_col_m1),
    .busy(busy), .done(done), .error(error),
    .dma_sxarid(arid), .dma_sxaraddr(araddr), .dma_sxarlen(arlen),
    .dma_sxarsize(arsize), .dma_sxarburst(arburst), .dma_sxarvalid(arvalid),
    .dma_sxarready(arready),
    .dma_sxrid(rid), .dma_sxrdata(rdata), .dma_sxrresp(rresp),
    .dma_sxrlast(rlast), .dma_sxrvalid(rvalid), .dma_sxrready(rready),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .row_last(row_last)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // reference configuration of the load in flight
  logic [31:0] m_sa, m_st, salt;
  logic [1:0]  m_nr, m_nc;

  // bus behaviour knobs
  bit ar_rand = 0, r_rand = 0, rr_rand = 0;
  int rdelay = 0, rr_hold_left = 0, err_row = -1, err_beat = -1;

  typedef struct {logic [31:0] addr; int rdy; int idx;} burst_t;
  burst_t       bq[$];
  logic [31:0]  ar_addrs[$];
  logic [127:0] got_data[$];
  bit           got_last[$];
  int  beat_no = 0, burst_cnt = 0, model_out = 0, max_out = 0;
  bit  r_hs = 0, prev_row_wait = 0, prev_ar_wait = 0;
  logic [127:0] prev_row_data;
  logic [31:0]  prev_araddr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  // expected row r: element c is the word at start + r*stride + 4c, or zero
  function automatic logic [127:0] exp_row(input int r);
    logic [127:0] v;
    v = '0;
    for (int c = 0; c < MS; c++)
      if (r <= int'(m_nr) && c <= int'(m_nc))
        v[c*32 +: 32] = mem_word(m_sa + 32'(r) * m_st + 32'(4 * c));
    return v;
  endfunction

  // AXI slave, row sink and protocol monitor, all acting on the falling edge
  initial begin
    bit held;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; rid = 0; row_ready = 0;
    forever begin
      @(negedge clk);
      cyc++;
      held = rvalid && !r_hs;
      arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bq.size() > 0 && cyc >= bq[0].rdy && (held || !r_rand || $urandom_range(0, 2) != 0)) begin
        rvalid = 1'b1;
        rdata  = mem_word(bq[0].addr + 32'(4 * beat_no));
        rlast  = (beat_no == BEATS - 1);
        rresp  = (bq[0].idx == err_row && beat_no == err_beat) ? 2'b10 : 2'b00;
      end else begin
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = '0;
      end
      if (rr_hold_left > 0 && row_valid) begin
        row_ready = 1'b0;
        rr_hold_left--;
      end else begin
        row_ready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      #1;
      if (!rstnn) begin
        bq.delete(); beat_no = 0; model_out = 0; r_hs = 0;
        rvalid = 1'b0; rlast = 1'b0;
        prev_row_wait = 0; prev_ar_wait = 0;
      end else begin
        if (prev_row_wait) begin
          n_cmp++;
          if (!row_valid || row_data !== prev_row_data) begin
            n_bad++;
            $display("[TB] FAIL row_hold: valid=%0b data=%h required valid=1 data=%h", row_valid, row_data, prev_row_data);
          end
        end
        if (prev_ar_wait) begin
          n_cmp++;
          if (!arvalid || araddr !== prev_araddr) begin
            n_bad++;
            $display("[TB] FAIL ar_hold: arvalid=%0b araddr=%h required arvalid=1 araddr=%h", arvalid, araddr, prev_araddr);
          end
        end
        if (row_valid) begin
          n_cmp++;
          if (rready !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL rready_while_row: rready=%0b required 0", rready);
          end
        end
        if (arvalid && arready) begin
          n_cmp++;
          if ({arlen, arsize, arburst, arid} !== {8'd3, 3'd2, 2'b01, 4'd0}) begin
            n_bad++;
            $display("[TB] FAIL ar_attr: len=%0d size=%0d burst=%0d id=%0d required 3/2/1/0", arlen, arsize, arburst, arid);
          end
          bq.push_back('{araddr, cyc + rdelay, burst_cnt});
          ar_addrs.push_back(araddr);
          burst_cnt++;
          model_out++;
          if (model_out > max_out) max_out = model_out;
          n_cmp++;
          if (model_out > MO) begin
            n_bad++;
            $display("[TB] FAIL outstanding_limit: in_flight=%0d required <= %0d", model_out, MO);
          end
        end
        r_hs = rvalid && rready;
        if (r_hs) begin
          if (rlast) begin
            void'(bq.pop_front());
            beat_no = 0;
            model_out--;
          end else begin
            beat_no++;
          end
        end
        if (row_valid && row_ready) begin
          got_data.push_back(row_data);
          got_last.push_back(row_last);
        end
        prev_row_wait = row_valid && !row_ready;
        prev_row_data = row_data;
        prev_ar_wait  = arvalid && !arready;
        prev_araddr   = araddr;
      end
    end
  end

  task automatic prep_load(input logic [31:0] sa, input logic [31:0] st, input logic [1:0] nr, input logic [1:0] nc);
    m_sa = sa; m_st = st; m_nr = nr; m_nc = nc;
    salt = $urandom;
    got_data.delete(); got_last.delete(); ar_addrs.delete();
    burst_cnt = 0; max_out = 0;
    cfg_start_addr = sa; cfg_stride = st; cfg_num_row_m1 = nr; cfg_num_col_m1 = nc;
  endtask

  task automatic run_load(input logic [31:0] sa, input logic [31:0] st, input logic [1:0] nr,
                          input logic [1:0] nc, output int done_cycles, output bit timed_out);
    prep_load(sa, st, nr, nc);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    done_cycles = 0; timed_out = 1;
    for (int i = 0; i < 3000; i++) begin
      #2;
      if (done) done_cycles++;
      if (!busy) begin timed_out = 0; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rstnn = 1'b0; start = 1'b0;
    cfg_start_addr = '0; cfg_stride = '0; cfg_num_row_m1 = '0; cfg_num_col_m1 = '0;
    repeat (3) @(negedge clk);
    #2;
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("[TB] FAIL reset_busy: got %0b required 0", busy); end
    n_cmp++; if (done !== 1'b0)       begin n_bad++; $display("[TB] FAIL reset_done: got %0b required 0", done); end
    n_cmp++; if (error !== 1'b0)      begin n_bad++; $display("[TB] FAIL reset_error: got %0b required 0", error); end
    n_cmp++; if (arvalid !== 1'b0)    begin n_bad++; $display("[TB] FAIL reset_arvalid: got %0b required 0", arvalid); end
    n_cmp++; if (rready !== 1'b0)     begin n_bad++; $display("[TB] FAIL reset_rready: got %0b required 0", rready); end
    n_cmp++; if (row_valid !== 1'b0)  begin n_bad++; $display("[TB] FAIL reset_row_valid: got %0b required 0", row_valid); end
    n_cmp++; if (row_last !== 1'b0)   begin n_bad++; $display("[TB] FAIL reset_row_last: got %0b required 0", row_last); end
    n_cmp++; if (araddr !== 32'h0)    begin n_bad++; $display("[TB] FAIL reset_araddr: got %h required 0", araddr); end
    n_cmp++; if (row_data !== 128'h0) begin n_bad++; $display("[TB] FAIL reset_row_data: got %h required 0", row_data); end
    @(negedge clk); rstnn = 1'b1;
  endtask

  task automatic test_basic;
    int dc; bit to;
    run_load(32'h1000, 32'h40, 2'd3, 2'd3, dc, to);
    n_cmp++; if (to || dc != 1) begin n_bad++; $display("[TB] FAIL basic_done: timeout=%0b done_cycles=%0d required 0/1", to, dc); end
    n_cmp++; if (ar_addrs.size() != 4) begin n_bad++; $display("[TB] FAIL basic_ar_count: got %0d required 4", ar_addrs.size()); end
    for (int i = 0; i < ar_addrs.size() && i < 4; i++) begin
      n_cmp++;
      if (ar_addrs[i] !== 32'h1000 + 32'(i) * 32'h40) begin
        n_bad++; $display("[TB] FAIL basic_araddr%0d: got %h required %h", i, ar_addrs[i], 32'h1000 + 32'(i) * 32'h40);
      end
    end
    n_cmp++; if (got_data.size() != MS) begin n_bad++; $display("[TB] FAIL basic_rows: got %0d required %0d", got_data.size(), MS); end
    for (int r = 0; r < got_data.size() && r < MS; r++) begin
      n_cmp++;
      if (got_data[r] !== exp_row(r) || got_last[r] != (r == MS - 1)) begin
        n_bad++; $display("[TB] FAIL basic_row%0d: data=%h last=%0b required data=%h last=%0b", r, got_data[r], got_last[r], exp_row(r), r == MS - 1);
      end
    end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("[TB] FAIL basic_error: got %0b required 0", error); end
  endtask

  task automatic test_masking;
    int dc; bit to;
    run_load($urandom, 32'($urandom_range(16, 4096)), 2'd1, 2'd1, dc, to);
    n_cmp++; if (to || dc != 1) begin n_bad++; $display("[TB] FAIL mask_done: timeout=%0b done_cycles=%0d required 0/1", to, dc); end
    n_cmp++; if (ar_addrs.size() != 2) begin n_bad++; $display("[TB] FAIL mask_ar_count: got %0d required 2", ar_addrs.size()); end
    n_cmp++; if (got_data.size() != MS) begin n_bad++; $display("[TB] FAIL mask_rows: got %0d required %0d", got_data.size(), MS); end
    for (int r = 0; r < got_data.size() && r < MS; r++) begin
      n_cmp++;
      if (got_data[r] !== exp_row(r) || got_last[r] != (r == MS - 1)) begin
        n_bad++; $display("[TB] FAIL mask_row%0d: data=%h last=%0b required data=%h last=%0b", r, got_data[r], got_last[r], exp_row(r), r == MS - 1);
      end
    end
  endtask

  task automatic test_outstanding;
    int dc; bit to;
    rdelay = 20;
    run_load($urandom, 32'h100, 2'd3, 2'd2, dc, to);
    rdelay = 0;
    n_cmp++; if (to || dc != 1) begin n_bad++; $display("[TB] FAIL outst_done: timeout=%0b done_cycles=%0d required 0/1", to, dc); end
    n_cmp++; if (max_out != MO) begin n_bad++; $display("[TB] FAIL outst_peak: got %0d required %0d", max_out, MO); end
    n_cmp++; if (got_data.size() != MS) begin n_bad++; $display("[TB] FAIL outst_rows: got %0d required %0d", got_data.size(), MS); end
    for (int r = 0; r < got_data.size() && r < MS; r++) begin
      n_cmp++;
      if (got_data[r] !== exp_row(r)) begin
        n_bad++; $display("[TB] FAIL outst_row%0d: got %h required %h", r, got_data[r], exp_row(r));
      end
    end
  endtask

  task automatic test_backpressure;
    int dc; bit to;
    rr_hold_left = 10;
    run_load($urandom, 32'h80, 2'd3, 2'd3, dc, to);
    n_cmp++; if (to || dc != 1) begin n_bad++; $display("[TB] FAIL bp_done: timeout=%0b done_cycles=%0d required 0/1", to, dc); end
    n_cmp++; if (rr_hold_left != 0) begin n_bad++; $display("[TB] FAIL bp_hold_used: left=%0d required 0", rr_hold_left); end
    n_cmp++; if (got_data.size() != MS) begin n_bad++; $display("[TB] FAIL bp_rows: got %0d required %0d", got_data.size(), MS); end
    for (int r = 0; r < got_data.size() && r < MS; r++) begin
      n_cmp++;
      if (got_data[r] !== exp_row(r)) begin
        n_bad++; $display("[TB] FAIL bp_row%0d: got %h required %h", r, got_data[r], exp_row(r));
      end
    end
  endtask

  task automatic test_slverr;
    int dc; bit to;
    err_row = 1; err_beat = 2;
    run_load($urandom, 32'h40, 2'd3, 2'd3, dc, to);
    err_row = -1; err_beat = -1;
    n_cmp++; if (to || dc != 1) begin n_bad++; $display("[TB] FAIL slverr_done: timeout=%0b done_cycles=%0d required 0/1", to, dc); end
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("[TB] FAIL slverr_error: got %0b required 1", error); end
    for (int r = 0; r < got_data.size() && r < MS; r++) begin
      n_cmp++;
      if (got_data[r] !== exp_row(r)) begin
        n_bad++; $display("[TB] FAIL slverr_row%0d: got %h required %h", r, got_data[r], exp_row(r));
      end
    end
    run_load($urandom, 32'h40, 2'd2, 2'd3, dc, to);
    n_cmp++; if (to || error !== 1'b0) begin n_bad++; $display("[TB] FAIL slverr_clear: timeout=%0b error=%0b required 0/0", to, error); end
  endtask

  task automatic test_random;
    int dc; bit to;
    ar_rand = 1; r_rand = 1; rr_rand = 1;
    for (int k = 0; k < 5; k++) begin
      rdelay = $urandom_range(0, 6);
      run_load($urandom, $urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), dc, to);
      n_cmp++; if (to || dc != 1) begin n_bad++; $display("[TB] FAIL rand%0d_done: timeout=%0b done_cycles=%0d required 0/1", k, to, dc); end
      n_cmp++; if (ar_addrs.size() != int'(m_nr) + 1) begin n_bad++; $display("[TB] FAIL rand%0d_ar_count: got %0d required %0d", k, ar_addrs.size(), int'(m_nr) + 1); end
      n_cmp++; if (got_data.size() != MS) begin n_bad++; $display("[TB] FAIL rand%0d_rows: got %0d required %0d", k, got_data.size(), MS); end
      for (int r = 0; r < got_data.size() && r < MS; r++) begin
        n_cmp++;
        if (got_data[r] !== exp_row(r) || got_last[r] != (r == MS - 1)) begin
          n_bad++; $display("[TB] FAIL rand%0d_row%0d: data=%h last=%0b required data=%h last=%0b", k, r, got_data[r], got_last[r], exp_row(r), r == MS - 1);
        end
      end
    end
    ar_rand = 0; r_rand = 0; rr_rand = 0; rdelay = 0;
  endtask

  task automatic test_back_to_back;
    bit seen;
    prep_load($urandom, 32'h20, 2'd3, 2'd1);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 0;
    for (int i = 0; i < 2000; i++) begin
      #2;
      if (done) begin seen = 1; break; end
      @(negedge clk);
    end
    n_cmp++; if (!seen || got_data.size() != MS) begin n_bad++; $display("[TB] FAIL b2b_first: done_seen=%0b rows=%0d required 1/%0d", seen, got_data.size(), MS); end
    start = 1'b1;
    @(negedge clk); #2;
    n_cmp++; if (busy !== 1'b0 || arvalid !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_ignored: busy=%0b arvalid=%0b required 0/0", busy, arvalid); end
    prep_load(m_sa + 32'h400, 32'h20, 2'd2, 2'd2);
    @(negedge clk); start = 1'b0; #2;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_accept: busy=%0b required 1", busy); end
    seen = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #2;
      if (!busy) begin seen = 1; break; end
    end
    n_cmp++; if (!seen || got_data.size() != MS) begin n_bad++; $display("[TB] FAIL b2b_second: finished=%0b rows=%0d required 1/%0d", seen, got_data.size(), MS); end
    for (int r = 0; r < got_data.size() && r < MS; r++) begin
      n_cmp++;
      if (got_data[r] !== exp_row(r)) begin
        n_bad++; $display("[TB] FAIL b2b_row%0d: got %h required %h", r, got_data[r], exp_row(r));
      end
    end
  endtask

  task automatic test_reset_midload;
    int dc; bit to, seen;
    rdelay = 20;
    prep_load($urandom, 32'h40, 2'd3, 2'd3);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      #2;
      if (model_out == 2) begin seen = 1; break; end
      @(negedge clk);
    end
    n_cmp++; if (!seen) begin n_bad++; $display("[TB] FAIL rstmid_reach: in_flight=%0d required 2", model_out); end
    @(negedge clk); rstnn = 1'b0; #2;
    n_cmp++;
    if ({busy, done, error, arvalid, rready, row_valid, row_last} !== 7'b0 || araddr !== 32'h0 || row_data !== 128'h0) begin
      n_bad++; $display("[TB] FAIL rstmid_outputs: ctl=%b araddr=%h row_data=%h required all zero",
                        {busy, done, error, arvalid, rready, row_valid, row_last}, araddr, row_data);
    end
    rdelay = 0;
    @(negedge clk); rstnn = 1'b1;
    run_load($urandom, 32'h60, 2'd3, 2'd2, dc, to);
    n_cmp++; if (to || dc != 1 || got_data.size() != MS) begin n_bad++; $display("[TB] FAIL rstmid_fresh: timeout=%0b done_cycles=%0d rows=%0d required 0/1/%0d", to, dc, got_data.size(), MS); end
    for (int r = 0; r < got_data.size() && r < MS; r++) begin
      n_cmp++;
      if (got_data[r] !== exp_row(r)) begin
        n_bad++; $display("[TB] FAIL rstmid_row%0d: got %h required %h", r, got_data[r], exp_row(r));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_masking();
    test_outstanding();
    test_backpressure();
    test_slverr();
    test_random();
    test_back_to_back();
    test_reset_midload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
